// File: rtl/tlb_pkg.sv
// Shared TLB sequencer constants: request opcodes, TLB op-port encodings, state encoding.
package tlb_pkg;

  localparam logic [2:0] TLBOP_P  = 3'b001;
  localparam logic [2:0] TLBOP_R  = 3'b010;
  localparam logic [2:0] TLBOP_WI = 3'b011;
  localparam logic [2:0] TLBOP_WR = 3'b100;

  localparam logic [1:0] TLB_OP_NORMAL = 2'b00;
  localparam logic [1:0] TLB_OP_READ   = 2'b01;
  localparam logic [1:0] TLB_OP_WI     = 2'b10;
  localparam logic [1:0] TLB_OP_WR     = 2'b11;

  typedef enum logic [2:0] {
    SIdle,
    SProbe,
    SRead,
    SReadWb,
    SWrite,
    SFlush,
    SErr
  } seqState_e;

endpackage

// File: rtl/tlb_flush_timer.sv
// Loadable down-counter that stops at zero; zero flag marks the last flush cycle.
module tlb_flush_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences COP0 TLBP/TLBR/TLBWI/TLBWR onto the shared TLB.
// Define TLB_UTLB_FLUSH_EN to add the post-write translation-prediction flush window.
module tlb_op_sequencer
  import tlb_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  input  logic [2:0]  reqOp,
  output logic        reqReady,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [1:0]  tlbOp,
  input  logic [31:0] probeIndex,
  output logic        indexWe,
  output logic [31:0] indexData,
  output logic        entryWe,
  output logic        utlbFlush
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : gBadFlushCycles
    $error("tlb_op_sequencer: FLUSH_CYCLES must be in 1..15");
  end

  seqState_e   state;
  seqState_e   nextState;
  logic [2:0]  opReg;
  logic        accept;

  assign accept = reqValid && (state == SIdle);

`ifdef TLB_UTLB_FLUSH_EN
  localparam int unsigned FlushCntW = 4;
  logic flushZero;

  tlb_flush_timer #(.CNT_W(FlushCntW)) uFlushTimer (
    .clk       (clk),
    .rst       (rst),
    .load      (state == SWrite),
    .loadValue (FlushCntW'(FLUSH_CYCLES - 1)),
    .zero      (flushZero)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SIdle;
    else     state <= nextState;
  end

  // Opcode and probe result are captured in the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opReg     <= '0;
      indexData <= '0;
    end else if (accept) begin
      opReg <= reqOp;
      if (reqOp == TLBOP_P) indexData <= probeIndex;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      SIdle: begin
        if (reqValid) begin
          case (reqOp)
            TLBOP_P:            nextState = SProbe;
            TLBOP_R:            nextState = SRead;
            TLBOP_WI, TLBOP_WR: nextState = SWrite;
            default:            nextState = SErr;
          endcase
        end
      end
      SRead:  nextState = SReadWb;
`ifdef TLB_UTLB_FLUSH_EN
      SWrite: nextState = SFlush;
      SFlush: if (flushZero) nextState = SIdle;
`else
      SWrite: nextState = SIdle;
      SFlush: nextState = SIdle;
`endif
      default: nextState = SIdle;
    endcase
  end

  // Moore decode of the state register; tlbOp is non-normal only in READ and WRITE.
  always_comb begin
    reqReady  = 1'b0;
    busy      = 1'b1;
    ack       = 1'b0;
    err       = 1'b0;
    tlbOp     = TLB_OP_NORMAL;
    indexWe   = 1'b0;
    entryWe   = 1'b0;
    utlbFlush = 1'b0;
    case (state)
      SIdle: begin
        reqReady = 1'b1;
        busy     = 1'b0;
      end
      SProbe: begin
        indexWe = 1'b1;
        ack     = 1'b1;
      end
      SRead:   tlbOp = TLB_OP_READ;
      SReadWb: begin
        entryWe = 1'b1;
        ack     = 1'b1;
      end
      SWrite: begin
        tlbOp = (opReg == TLBOP_WR) ? TLB_OP_WR : TLB_OP_WI;
`ifndef TLB_UTLB_FLUSH_EN
        ack   = 1'b1;
`endif
      end
      SFlush: begin
`ifdef TLB_UTLB_FLUSH_EN
        utlbFlush = 1'b1;
        ack       = flushZero;
`endif
      end
      SErr: begin
        ack = 1'b1;
        err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
